// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder step per clock, LSB first.
// Owns operand shift registers, carry flop, bit counter and start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, res_sh;
    logic             carry, cmsb;
    logic [CW-1:0]    cnt;
    logic             sum, cout, accept, last;

    // The single full-adder cell.
    assign sum  = sa[0] ^ sb[0] ^ carry;
    assign cout = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));

    assign accept = (state != RUN) && start;
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cmsb      <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1: invert b here and seed the carry with sub.
            sa    <= a;
            sb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            res_sh <= {sum, res_sh[WIDTH-1:1]};
            carry  <= cout;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 2)) cmsb <= cout;
            if (last) begin
                result    <= {sum, res_sh[WIDTH-1:1]};
                carry_out <= cout;
                overflow  <= cmsb ^ cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH = 8).
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One accepted op: start pulsed for one edge, then measure latency and check outputs.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                          input logic [W-1:0] er, input logic eco, input logic eov);
        int lat;
        int busy_bad;
        @(negedge clk);
        a = va; b = vb; sub = vs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        lat = 0;
        busy_bad = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!done && !busy) busy_bad++;
        end
        chk("latency", lat, W);
        chk("busy_gap", busy_bad, 0);
        chk("busy_in_done", int'(busy), 0);
        chk("result", int'(result), int'(er));
        chk("carry_out", int'(carry_out), int'(eco));
        chk("overflow", int'(overflow), int'(eov));
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        int last_done;
        vecs[0] = '{8'd5,   8'd3,   1'b0, 8'd8,    1'b0, 1'b0};
        vecs[1] = '{8'd200, 8'd100, 1'b0, 8'd44,   1'b1, 1'b0};
        vecs[2] = '{8'd127, 8'd1,   1'b0, 8'd128,  1'b0, 1'b1};
        vecs[3] = '{8'd3,   8'd5,   1'b1, 8'd254,  1'b0, 1'b0};
        vecs[4] = '{8'h80,  8'd1,   1'b1, 8'h7F,   1'b1, 1'b1};
        vecs[5] = '{8'd0,   8'd0,   1'b0, 8'd0,    1'b0, 1'b0};
        vecs[6] = '{8'hFF,  8'd1,   1'b0, 8'd0,    1'b1, 1'b0};
        vecs[7] = '{8'd10,  8'd10,  1'b1, 8'd0,    1'b1, 1'b0};
        vecs[8] = '{8'h7F,  8'hFF,  1'b1, 8'h80,   1'b0, 1'b1};
        vecs[9] = '{8'hFF,  8'hFF,  1'b0, 8'hFE,   1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_carry", int'(carry_out), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].co, vecs[i].ov);

        // Start while busy is ignored; result holds across the new start.
        @(negedge clk);
        a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_result_in_run", int'(result), 8'hFE);
        @(negedge clk);
        @(negedge clk);
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'd99; b = 8'd99; sub = 1'b1;
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        chk("ignore_done_seen", int'(done), 1);
        chk("ignore_result", int'(result), 30);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("ignore_no_second_op", seen, 0);

        // Reset mid-run clears outputs asynchronously and suppresses done.
        @(negedge clk);
        a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_result", int'(result), 0);
        chk("async_rst_flags", int'({done, carry_out, overflow}), 0);
        seen = 0;
        repeat (2) begin @(negedge clk); if (done) seen++; end
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (done || busy) seen++; end
        chk("no_done_after_abort", seen, 0);
        run_op(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);

        // Start held high: back-to-back ops every W+1 cycles.
        @(negedge clk);
        a = 8'd1; b = 8'd1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        seen = 0; last_done = -1;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            if (done) begin
                chk("b2b_busy_low", int'(busy), 0);
                chk("b2b_result", int'(result), 2);
                if (last_done >= 0) chk("b2b_interval", c - last_done, W + 1);
                else chk("b2b_first_latency", c, W);
                last_done = c;
                seen++;
            end else if (!busy) begin
                chk("b2b_busy_high", int'(busy), 1);
            end
            @(negedge clk);
        end
        chk("b2b_pulse_count", seen, 4);
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract on a single full_adder cell, one bit per clock, LSB first. It trades the area of a full ripple-carry chain for WIDTH cycles of latency. It owns the operand shift registers, the carry flop, the bit counter and the start/busy/done handshake. It sits between switch/register-driven operand sources and the LED/result display logic.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge only when the block is in IDLE or DONE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse; result, carry_out and overflow are valid from this cycle onward
result  output  WIDTH  sum or difference, registered
carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow
overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; shift registers, carry flop and bit counter cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at edge E0: latch a into shift reg SA; latch b (or ~b when sub=1) into SB; carry flop = sub; bit counter = 0; go to RUN; busy=1; done=0.
- IDLE/DONE, start=0: stay in IDLE. In DONE, return to IDLE at the next edge and clear done.
- RUN, each edge: full_adder(SA[0], SB[0], carry) -> sum bit, cout.
  - Sum bit shifts into the MSB end of the result shift register; SA and SB shift right; carry flop = cout; counter++.
  - At the bit WIDTH-2 step, capture cout as cmsb (carry into MSB).
- RUN exit, at the edge processing bit WIDTH-1 (edge E_WIDTH): load result, carry_out = final cout, overflow = cmsb ^ cout; go to DONE; busy=0; done=1 for exactly one cycle.
- Latency: start sampled at E0, done high during the cycle after E_WIDTH (WIDTH edges after acceptance). Throughput: one op per WIDTH+1 cycles when start is held high.
- start while busy=1: ignored. Operand/sub changes during RUN have no effect.
- result, carry_out and overflow hold their last values until the next completion. They are not cleared on start.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1.

Test Plan:
- Reset, then start with a=5, b=3, sub=0 -> busy=1 for 8 cycles; done pulses one cycle at the 8th edge after acceptance; result=8, carry_out=0, overflow=0.
- a=200, b=100, sub=0 -> result=44, carry_out=1, overflow=0. Then a=127, b=1 -> result=128, carry_out=0, overflow=1.
- a=3, b=5, sub=1 -> result=254, carry_out=0 (borrow), overflow=0. Then a=0x80, b=1, sub=1 -> result=0x7F, carry_out=1, overflow=1.
- Pulse start with a=1, b=1 at cycle 3 of a running a=10, b=20 add -> first result=30, done pulses once; second request is never executed.
- Assert rst_n low at cycle 4 of RUN -> busy, done, result, carry_out and overflow go to 0 immediately without waiting for clk; no done pulse; next start after release completes normally.
- Hold start high with a=1, b=1 -> back-to-back ops; done pulses every 9 cycles; result=2 each time; busy low exactly during the done cycle.
